// File: rtl/mod_dp.sv
// rtl/mod_dp.sv - restoring-style repeated-subtraction divider datapath
module mod_dp #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             loadA,
  input  logic             doSub,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  output logic             x,
  output logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] Q,
  output logic             divZero,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] A_reg;
  logic [WIDTH-1:0] B_reg;
  logic [WIDTH-1:0] Q_reg;
  logic             done_reg;

  // A zero divisor counts as complete so the control unit always terminates.
  assign divZero = (B_reg == '0);
  assign x       = (A_reg < B_reg) | divZero;

  assign R    = A_reg;
  assign Q    = Q_reg;
  assign done = done_reg;

  always_ff @(posedge CLK) begin
    if (reset) begin
      A_reg    <= '0;
      B_reg    <= '0;
      Q_reg    <= '0;
      done_reg <= 1'b0;
    end else if (loadA) begin
      A_reg    <= A_in;
      B_reg    <= B_in;
      Q_reg    <= '0;
      done_reg <= 1'b0;
    end else if (doSub) begin
      // Subtraction is gated by x, so A_reg can never wrap below zero.
      if (!x) begin
        A_reg <= A_reg - B_reg;
        Q_reg <= Q_reg + ONE;
      end else begin
        done_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mod_dp.sv
// tb/tb_mod_dp.sv - scoreboard bench for mod_dp with a division reference model
module tb_mod_dp;

  localparam int WIDTH = 8;

  logic             CLK = 1'b0;
  logic             reset;
  logic             loadA;
  logic             doSub;
  logic [WIDTH-1:0] A_in;
  logic [WIDTH-1:0] B_in;
  logic             x;
  logic [WIDTH-1:0] R;
  logic [WIDTH-1:0] Q;
  logic             divZero;
  logic             done;

  mod_dp #(.WIDTH(WIDTH)) dut (
    .CLK(CLK), .reset(reset), .loadA(loadA), .doSub(doSub),
    .A_in(A_in), .B_in(B_in), .x(x), .R(R), .Q(Q),
    .divZero(divZero), .done(done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int rem;
    int quo;
    int dz;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  logic done_q = 1'b0;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got == want) passed++;
    else $display("FAIL %s: got %0d, want %0d", name, got, want);
  endtask

  // Reference model: plain integer division, divide-by-zero leaves dividend.
  function automatic exp_t model(input int a, input int b);
    exp_t e;
    e.dz  = (b == 0);
    e.rem = (b == 0) ? a : a % b;
    e.quo = (b == 0) ? 0 : a / b;
    return e;
  endfunction

  // Monitor: a rising done presents a finished result to the scoreboard.
  always @(negedge CLK) begin
    if (done && !done_q) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result_R", int'(R), e.rem);
        check("result_Q", int'(Q), e.quo);
        check("result_divZero", int'(divZero), e.dz);
        check("result_x", int'(x), 1);
      end
    end
    done_q <= done;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load(input int a, input int b, input bit push);
    loadA = 1'b1;
    doSub = 1'b0;
    A_in  = WIDTH'(a);
    B_in  = WIDTH'(b);
    tick();
    loadA = 1'b0;
    if (push) exp_q.push_back(model(a, b));
  endtask

  // Holds doSub until done, checking edge count and post-done stability.
  task automatic reduce(input string tag, input int a, input int b);
    exp_t e;
    int   cycles;
    int   want_cycles;
    e = model(a, b);
    want_cycles = (b == 0) ? 1 : a / b + 1;
    check({tag, "_x_after_load"}, int'(x), (a < b || b == 0) ? 1 : 0);
    doSub  = 1'b1;
    cycles = 0;
    while (!done && cycles < 400) begin
      tick();
      cycles++;
    end
    check({tag, "_edges_to_done"}, cycles, want_cycles);
    tick();
    check({tag, "_hold_R"}, int'(R), e.rem);
    check({tag, "_hold_Q"}, int'(Q), e.quo);
    check({tag, "_sticky_done"}, int'(done), 1);
    doSub = 1'b0;
    tick();
  endtask

  task automatic run_div(input string tag, input int a, input int b);
    load(a, b, 1'b1);
    reduce(tag, a, b);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; loadA = 1'b0; doSub = 1'b0; A_in = '0; B_in = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_R", int'(R), 0);
    check("rst_Q", int'(Q), 0);
    check("rst_done", int'(done), 0);
    check("rst_divZero", int'(divZero), 1);
    check("rst_x", int'(x), 1);

    run_div("d17_5", 17, 5);
    run_div("d3_7", 3, 7);
    run_div("d200_0", 200, 0);
    run_div("d255_1", 255, 1);

    // Reset mid-reduction abandons the operation.
    load(17, 5, 1'b0);
    doSub = 1'b1;
    tick(); tick();
    check("mid_Q_before_reset", int'(Q), 2);
    reset = 1'b1;
    tick();
    reset = 1'b0; doSub = 1'b0;
    check("abort_R", int'(R), 0);
    check("abort_Q", int'(Q), 0);
    check("abort_done", int'(done), 0);
    check("abort_x", int'(x), 1);
    run_div("d9_4", 9, 4);

    // Simultaneous loadA and doSub: load wins.
    load(10, 3, 1'b0);
    loadA = 1'b1; doSub = 1'b1; A_in = 8'd20; B_in = 8'd6;
    tick();
    loadA = 1'b0; doSub = 1'b0;
    check("both_R", int'(R), 20);
    check("both_Q", int'(Q), 0);
    exp_q.push_back(model(20, 6));
    reduce("d20_6", 20, 6);

    // Idle hold.
    tick(); tick();
    check("idle_R", int'(R), 2);
    check("idle_Q", int'(Q), 3);

    for (int i = 0; i < 24; i++) begin
      int a;
      int b;
      a = $urandom_range(0, 255);
      b = (i % 3 == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
      run_div($sformatf("rnd%0d", i), a, b);
    end

    tick(); tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
